switch_debounce_edge: RTL and testbench
=======================================

SWITCH_DEBOUNCE_EDGE -- requirements
Module: switch_debounce_edge

Interface
REQ-001 SHALL have parameter TOT_DEBOUNCE_CLICK, default 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); legal range 1..2^CNT_WIDTH-1.
REQ-002 SHALL have parameter CNT_WIDTH, default 18, width of the debounce counter.
REQ-003 SHALL have parameter REPEAT_DELAY, default 12500000, cycles from accepted press to first repeat pulse (500 ms); legal range >=1.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 2500000, cycles between subsequent repeat pulses (100 ms); legal range >=1.
REQ-005 SHALL have parameter RPT_WIDTH, default 24, width of the repeat counter.
REQ-006 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port i_switch, input, 1 bit: raw switch level, asynchronous to i_clk, 1 = pressed.
REQ-009 SHALL have port o_switch, output, 1 bit: debounced switch level.
REQ-010 SHALL have port o_on_pulse, output, 1 bit: one-cycle strobe on an accepted 0->1 change.
REQ-011 SHALL have port o_off_pulse, output, 1 bit: one-cycle strobe on an accepted 1->0 change.
REQ-012 SHALL have port o_repeat_pulse, output, 1 bit: one-cycle hold-to-repeat strobe.

Function
REQ-013 SHALL pass i_switch through a two-flop synchronizer; only the second flop output (sync) is used downstream.
REQ-014 SHALL implement FSM states STABLE_OFF, WAIT_ON, STABLE_ON, WAIT_OFF.
REQ-015 STABLE_OFF -> WAIT_ON when sync=1; STABLE_ON -> WAIT_OFF when sync=0; counter loaded to 1 on entry.
REQ-016 In WAIT_x: sync reverting to the stable level returns to the previous STABLE state with the counter cleared, and no output changes.
REQ-017 In WAIT_x: when the counter equals TOT_DEBOUNCE_CLICK with sync still differing, the FSM SHALL enter the new STABLE state, toggle o_switch, and assert the matching pulse in that same cycle.
REQ-018 Counter SHALL increment by 1 per WAIT cycle, never wrap, and clear in STABLE states.
REQ-019 For TOT_DEBOUNCE_CLICK=1, a single cycle of differing sync SHALL suffice.
REQ-020 Latency: a clean raw edge SHALL appear on o_switch exactly TOT_DEBOUNCE_CLICK+2 rising edges after the first edge that samples the new raw level.
REQ-021 o_on_pulse and o_off_pulse SHALL each be high for exactly one cycle per accepted change, and never together.
REQ-022 Glitches shorter than TOT_DEBOUNCE_CLICK sync cycles SHALL produce no output activity.

Reset
REQ-023 i_reset high SHALL immediately clear synchronizer flops, counters, FSM (STABLE_OFF), o_switch, and all pulses to 0.
REQ-024 Reset mid-WAIT or mid-repeat SHALL abandon the operation; no pulse SHALL be emitted on or after reset release except through a fresh full debounce.
REQ-025 If i_switch is held 1 through reset release, o_on_pulse SHALL fire TOT_DEBOUNCE_CLICK+2 cycles after release.

Configuration
REQ-026 Macro NS_DEBOUNCE_AUTOREPEAT_EN SHALL compile in the repeat logic; when defined, while in STABLE_ON a repeat counter SHALL start at the on-pulse and assert o_repeat_pulse REPEAT_DELAY cycles after it, then every REPEAT_PERIOD cycles, until exit from STABLE_ON.
REQ-027 With the macro defined, entering WAIT_OFF SHALL freeze the repeat counter; returning to STABLE_ON SHALL resume it; accepting the off change SHALL clear it.
REQ-028 Without the macro, o_repeat_pulse SHALL be constant 0, the port SHALL remain present, and no repeat counter SHALL be synthesized.
REQ-029 o_repeat_pulse SHALL never coincide with o_on_pulse or o_off_pulse.

Verification (TOT_DEBOUNCE_CLICK=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-030 Raw 0->1 at cycle 0, then held -> o_switch=1 and o_on_pulse=1 at cycle 6 only.
REQ-031 Raw high for 3 cycles, then low -> o_switch stays 0; no pulses.
REQ-032 Press accepted, raw 1->0 held -> o_off_pulse for one cycle 6 cycles after the raw fall; o_switch=0.
REQ-033 Reset asserted at cycle 4 of a 6-cycle press acceptance with raw held 1 -> no pulse; o_on_pulse 6 cycles after reset release.
REQ-034 Macro defined, press held from on-pulse at cycle T -> o_repeat_pulse at T+8, T+11, T+14; none after release is accepted.
REQ-035 Macro undefined, same stimulus as REQ-034 -> o_repeat_pulse stays 0.

Source files
------------

// File: rtl/switch_debounce_edge.sv
// Switch debouncer with two-flop synchronizer, edge strobes and an optional hold-to-repeat strobe.
// Optional feature: define NS_DEBOUNCE_AUTOREPEAT_EN to build the auto-repeat counter.
module switch_debounce_edge #(
    parameter int TOT_DEBOUNCE_CLICK = 250000,
    parameter int CNT_WIDTH          = 18,
    parameter int REPEAT_DELAY       = 12500000,
    parameter int REPEAT_PERIOD      = 2500000,
    parameter int RPT_WIDTH          = 24
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_switch,
    output logic o_switch,
    output logic o_on_pulse,
    output logic o_off_pulse,
    output logic o_repeat_pulse
);

    typedef enum logic [1:0] {
        STABLE_OFF,
        WAIT_ON,
        STABLE_ON,
        WAIT_OFF
    } state_t;

    localparam logic [CNT_WIDTH-1:0] L_TOT = CNT_WIDTH'(TOT_DEBOUNCE_CLICK);
    localparam logic [CNT_WIDTH-1:0] L_ONE = CNT_WIDTH'(1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 r_switch;
    logic                 w_switch_next;
    logic                 r_on_pulse;
    logic                 w_on_next;
    logic                 r_off_pulse;
    logic                 w_off_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_switch;
            r_sync2 <= r_sync1;
        end
    end

    // Saturate instead of wrapping so an oversized stable run can never alias back to a small count.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + L_ONE;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = '0;
        w_switch_next = r_switch;
        w_on_next     = 1'b0;
        w_off_next    = 1'b0;
        case (r_state)
            STABLE_OFF: begin
                if (r_sync2) begin
                    w_state_next = WAIT_ON;
                    w_cnt_next   = L_ONE;
                end
            end
            WAIT_ON: begin
                if (!r_sync2) begin
                    w_state_next = STABLE_OFF;
                end else if (r_cnt == L_TOT) begin
                    w_state_next  = STABLE_ON;
                    w_switch_next = 1'b1;
                    w_on_next     = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            STABLE_ON: begin
                if (!r_sync2) begin
                    w_state_next = WAIT_OFF;
                    w_cnt_next   = L_ONE;
                end
            end
            WAIT_OFF: begin
                if (r_sync2) begin
                    w_state_next = STABLE_ON;
                end else if (r_cnt == L_TOT) begin
                    w_state_next  = STABLE_OFF;
                    w_switch_next = 1'b0;
                    w_off_next    = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next  = STABLE_OFF;
                w_switch_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= STABLE_OFF;
            r_cnt       <= '0;
            r_switch    <= 1'b0;
            r_on_pulse  <= 1'b0;
            r_off_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_switch    <= w_switch_next;
            r_on_pulse  <= w_on_next;
            r_off_pulse <= w_off_next;
        end
    end

    assign o_switch    = r_switch;
    assign o_on_pulse  = r_on_pulse;
    assign o_off_pulse = r_off_pulse;

`ifdef NS_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [RPT_WIDTH-1:0] L_DELAY_M1  = RPT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [RPT_WIDTH-1:0] L_PERIOD_M1 = RPT_WIDTH'(REPEAT_PERIOD - 1);

    logic [RPT_WIDTH-1:0] r_rpt_cnt;
    logic                 r_rpt_pulse;

    // Down-counter armed by the on-pulse; it only moves while STABLE_ON, so WAIT_OFF holds it frozen.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rpt_cnt   <= '0;
            r_rpt_pulse <= 1'b0;
        end else begin
            r_rpt_pulse <= 1'b0;
            if (w_on_next) begin
                r_rpt_cnt <= L_DELAY_M1;
            end else if (w_off_next) begin
                r_rpt_cnt <= '0;
            end else if (r_state == STABLE_ON) begin
                if (r_rpt_cnt == '0) begin
                    r_rpt_pulse <= 1'b1;
                    r_rpt_cnt   <= L_PERIOD_M1;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt - RPT_WIDTH'(1);
                end
            end
        end
    end

    assign o_repeat_pulse = r_rpt_pulse;
`else
    // Evaluates to constant 0 for every legal parameter set; it only keeps the repeat parameters referenced.
    assign o_repeat_pulse = (REPEAT_DELAY < 1) && (REPEAT_PERIOD < 1) && (RPT_WIDTH < 1);
`endif

endmodule

// File: tb/tb_switch_debounce_edge.sv
// Self-checking bench for switch_debounce_edge: expected strobe events are queued when stimulus is driven
// and matched against observed strobes by a monitor.
module tb_switch_debounce_edge;

    localparam int TOT    = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 3;
    localparam int LAT    = TOT + 3;
    localparam int KIND_ON  = 1;
    localparam int KIND_OFF = 2;
    localparam int KIND_RPT = 3;

    typedef struct {
        int cycle;
        int kind;
    } event_t;

    logic clk;
    logic rst;
    logic swIn;
    logic swOut;
    logic onPulse;
    logic offPulse;
    logic rptPulse;

    int     cyc;
    int     errors;
    int     checks;
    event_t expQ[$];

    switch_debounce_edge #(
        .TOT_DEBOUNCE_CLICK(TOT),
        .CNT_WIDTH(18),
        .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD),
        .RPT_WIDTH(24)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_switch(swIn),
        .o_switch(swOut),
        .o_on_pulse(onPulse),
        .o_off_pulse(offPulse),
        .o_repeat_pulse(rptPulse)
    );

    // Free-running clock and a bench cycle count equal to the number of rising edges seen so far.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Match one observed strobe against the oldest queued expectation.
    task automatic handleEvent(input int kind, input int level, input int expLevel);
        event_t e;
        if (expQ.size() == 0) begin
            checkOutput("spuriousPulse", kind, 0);
        end else begin
            e = expQ.pop_front();
            checkOutput("pulseKind", kind, e.kind);
            checkOutput("pulseCycle", cyc, e.cycle);
            checkOutput("pulseLevel", level, expLevel);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (onPulse)  handleEvent(KIND_ON, int'(swOut), 1);
            if (offPulse) handleEvent(KIND_OFF, int'(swOut), 0);
            if (rptPulse) handleEvent(KIND_RPT, int'(swOut), 1);
        end
    end

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic applyStimulus(input int atCycle, input logic level);
        waitUntil(atCycle);
        swIn = level;
    endtask

    task automatic pushEvent(input int cycle, input int kind);
        event_t e;
        e.cycle = cycle;
        e.kind  = kind;
        expQ.push_back(e);
    endtask

    // Expected strobes for a press already sampled from driveCycle+1, held until holdAfterOn cycles past the on-pulse.
    task automatic expectPress(input int driveCycle, input int holdAfterOn);
        int onCyc;
        int relCyc;
        onCyc  = driveCycle + LAT;
        relCyc = onCyc + holdAfterOn;
        pushEvent(onCyc, KIND_ON);
`ifdef NS_DEBOUNCE_AUTOREPEAT_EN
        for (int t = onCyc + DELAY; t <= relCyc + 3; t += PERIOD) pushEvent(t, KIND_RPT);
`endif
        pushEvent(relCyc + LAT, KIND_OFF);
    endtask

    initial begin
        int p;
        int onCyc;
        int g;
        int a;
        int d;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        swIn   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetSwitch", int'(swOut), 0);
        checkOutput("resetOn", int'(onPulse), 0);
        checkOutput("resetOff", int'(offPulse), 0);
        checkOutput("resetRpt", int'(rptPulse), 0);
        rst = 1'b0;

        $display("[TB] clean press, held through repeats, then released");
        p     = cyc + 2;
        onCyc = p + LAT;
        expectPress(p, 12);
        applyStimulus(p, 1'b1);
        waitUntil(onCyc - 1);
        checkOutput("preAcceptLevel", int'(swOut), 0);
        waitUntil(onCyc + 5);
        checkOutput("holdLevel", int'(swOut), 1);
        applyStimulus(onCyc + 12, 1'b0);
        waitUntil(onCyc + 12 + LAT + 2);
        checkOutput("releasedLevel", int'(swOut), 0);

        $display("[TB] three-cycle glitch");
        g = cyc + 3;
        applyStimulus(g, 1'b1);
        applyStimulus(g + 3, 1'b0);
        waitUntil(g + 14);
        checkOutput("glitchLevel", int'(swOut), 0);

        $display("[TB] reset during acceptance with the switch held");
        a = cyc + 2;
        applyStimulus(a, 1'b1);
        waitUntil(a + 4);
        rst = 1'b1;
        #1;
        checkOutput("midResetSwitch", int'(swOut), 0);
        checkOutput("midResetOn", int'(onPulse), 0);
        waitUntil(a + 6);
        rst = 1'b0;
        d   = cyc;
        expectPress(d, 10);
        applyStimulus(d + LAT + 10, 1'b0);
        waitUntil(d + LAT + 10 + LAT + 10);

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
